// File: rtl/jtcastle_romarb.sv
// -----------------------------------------------------------------------------
// jtcastle_romarb
//
// Purpose:
//   Arbitrates the single SDRAM ROM slot between the main CPU (banked program
//   ROM) and the sound CPU. Each requester has a one-entry latch holding the
//   address tag, data byte and valid flag. A requester is answered straight
//   from its latch when its address matches the tag. Otherwise a downstream
//   fetch is issued. When both requesters need the slot at the same time,
//   they are served round-robin.
//
// Parameters:
//   MAIN_AW   main CPU ROM address width
//   SND_AW    sound CPU ROM address width
//   OUT_AW    downstream ROM address width
//   SND_BASE  downstream byte offset of the sound ROM region
//   TIMEOUT   cycles to wait for rom_ok before giving up (timeout build only)
//
// Ports:
//   clk        system clock (48 MHz)
//   rst_n      asynchronous active-low reset
//   main_cs    main CPU ROM request
//   main_addr  main CPU ROM address
//   main_data  latched data for main
//   main_ok    main_data is valid for the current main_addr
//   snd_cs     sound CPU ROM request
//   snd_addr   sound CPU ROM address
//   snd_data   latched data for sound
//   snd_ok     snd_data is valid for the current snd_addr
//   rom_cs     downstream request
//   rom_addr   downstream address, held stable for the whole grant
//   rom_data   downstream data
//   rom_ok     downstream data valid
//   rom_err    sticky timeout flag
//
// Build options:
//   JTCASTLE_ROMARB_TIMEOUT_EN
//     When this macro is defined, a grant that sees no rom_ok for TIMEOUT
//     cycles is closed with data 8'hFF, and rom_err is set. When the macro
//     is not defined, a grant waits for rom_ok indefinitely and rom_err is
//     tied to 0.
// -----------------------------------------------------------------------------
module jtcastle_romarb #(
    parameter int                MAIN_AW  = 18,
    parameter int                SND_AW   = 15,
    parameter int                OUT_AW   = 19,
    parameter logic [OUT_AW-1:0] SND_BASE = 'h40000,
    parameter int                TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               main_cs,
    input  logic [MAIN_AW-1:0] main_addr,
    output logic [7:0]         main_data,
    output logic               main_ok,

    input  logic               snd_cs,
    input  logic [SND_AW-1:0]  snd_addr,
    output logic [7:0]         snd_data,
    output logic               snd_ok,

    output logic               rom_cs,
    output logic [OUT_AW-1:0]  rom_addr,
    input  logic [7:0]         rom_data,
    input  logic               rom_ok,
    output logic               rom_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAIN = 2'd1;
    localparam logic [1:0] SND  = 2'd2;

    logic [1:0]         state;
    logic               first;      // first cycle of a grant: rom_ok may be stale
    logic               last_snd;   // 1 = sound was served last

    logic [MAIN_AW-1:0] main_tag;
    logic               main_vld;
    logic [SND_AW-1:0]  snd_tag;
    logic               snd_vld;

    logic               main_pend;
    logic               snd_pend;
    logic               grant_main;
    logic               grant_snd;
    logic               busy;
    logic               take;       // real capture of rom_data
    logic               tmo;        // grant abandoned after the timeout
    logic               fin;        // grant closes at this edge
    logic [7:0]         cap_data;

    // ---- latch lookup: hit/pending decode from the per-requester latches ----
    assign main_ok   = main_cs & main_vld & (main_addr == main_tag);
    assign snd_ok    = snd_cs  & snd_vld  & (snd_addr  == snd_tag);
    assign main_pend = main_cs & ~main_ok;
    assign snd_pend  = snd_cs  & ~snd_ok;

    // When both requesters are pending, main wins only if sound was served last.
    assign grant_main = (state == IDLE) & main_pend & (~snd_pend | last_snd);
    assign grant_snd  = (state == IDLE) & snd_pend  & ~grant_main;

    assign busy     = (state == MAIN) | (state == SND);
    assign take     = busy & ~first & rom_ok;
    assign fin      = take | tmo;
    // A timed-out grant is closed as if the ROM had returned 8'hFF.
    assign cap_data = take ? rom_data : 8'hFF;

`ifdef JTCASTLE_ROMARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] wait_cnt;
    logic          err_flag;

    // The counter is cleared while idle, so it starts at zero in the first
    // grant cycle. The grant is abandoned at the edge that ends cycle TIMEOUT.
    assign tmo = busy & ~take & (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_flag <= 1'b0;
        end else begin
            if (!busy || fin) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (tmo) begin
                err_flag <= 1'b1;
            end
        end
    end

    assign rom_err = err_flag;
`else
    assign tmo     = 1'b0;
    assign rom_err = 1'b0;
`endif

    // ---- grant / fetch control ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            first    <= 1'b0;
            last_snd <= 1'b1;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_main) begin
                        state    <= MAIN;
                        first    <= 1'b1;
                        last_snd <= 1'b0;
                        rom_cs   <= 1'b1;
                        rom_addr <= OUT_AW'(main_addr);
                    end else if (grant_snd) begin
                        state    <= SND;
                        first    <= 1'b1;
                        last_snd <= 1'b1;
                        rom_cs   <= 1'b1;
                        // Wraps modulo 2^OUT_AW.
                        rom_addr <= SND_BASE + OUT_AW'(snd_addr);
                    end
                end
                MAIN, SND: begin
                    first <= 1'b0;
                    if (fin) begin
                        // Returning through IDLE leaves one idle cycle
                        // between consecutive grants.
                        state  <= IDLE;
                        rom_cs <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    first  <= 1'b0;
                    rom_cs <= 1'b0;
                end
            endcase
        end
    end

    // ---- per-requester latches ----
    // The tag is written when the fetch is issued, not when it completes.
    // If the CPU moves to another address during a fetch, the returned
    // byte is stored under the old tag. The tag then mismatches, and the
    // next IDLE cycle issues a new request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_tag  <= '0;
            main_vld  <= 1'b0;
            main_data <= 8'h00;
        end else begin
            if (grant_main) begin
                main_tag <= main_addr;
                main_vld <= 1'b0;
            end else if (state == MAIN && fin) begin
                main_data <= cap_data;
                main_vld  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snd_tag  <= '0;
            snd_vld  <= 1'b0;
            snd_data <= 8'h00;
        end else begin
            if (grant_snd) begin
                snd_tag <= snd_addr;
                snd_vld <= 1'b0;
            end else if (state == SND && fin) begin
                snd_data <= cap_data;
                snd_vld  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jtcastle_romarb.sv
// -----------------------------------------------------------------------------
// tb_jtcastle_romarb
//
// Self-checking bench for jtcastle_romarb. It has three parts:
//   - a table of single-requester fetches;
//   - hand-written sequences for arbitration, stale rom_ok, address changes
//     and dropped cs during a fetch, and reset in the middle of a fetch;
//   - a randomised phase checked against rules derived from the ROM
//     contents model.
// Compile with JTCASTLE_ROMARB_TIMEOUT_EN defined to also cover the timeout
// sequence.
// -----------------------------------------------------------------------------
module tb_jtcastle_romarb;

    localparam int          MAIN_AW  = 18;
    localparam int          SND_AW   = 15;
    localparam int          OUT_AW   = 19;
    localparam logic [18:0] SND_BASE = 19'h40000;

    logic               clk;
    logic               rst_n;
    logic               main_cs;
    logic [MAIN_AW-1:0] main_addr;
    logic [7:0]         main_data;
    logic               main_ok;
    logic               snd_cs;
    logic [SND_AW-1:0]  snd_addr;
    logic [7:0]         snd_data;
    logic               snd_ok;
    logic               rom_cs;
    logic [OUT_AW-1:0]  rom_addr;
    logic [7:0]         rom_data;
    logic               rom_ok;
    logic               rom_err;

    // The downstream side is driven either directly by the directed code or,
    // in random mode, by a ROM model. The model returns romf(rom_addr) and
    // asserts ok at random.
    logic               rnd_mode;
    logic               rnd_ok;
    logic               dir_ok;
    logic [7:0]         dir_data;

    int vectors = 0;
    int errs    = 0;

    jtcastle_romarb #(
        .MAIN_AW  (MAIN_AW),
        .SND_AW   (SND_AW),
        .OUT_AW   (OUT_AW),
        .SND_BASE (SND_BASE),
        .TIMEOUT  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .main_cs   (main_cs),
        .main_addr (main_addr),
        .main_data (main_data),
        .main_ok   (main_ok),
        .snd_cs    (snd_cs),
        .snd_addr  (snd_addr),
        .snd_data  (snd_data),
        .snd_ok    (snd_ok),
        .rom_cs    (rom_cs),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rom_ok    (rom_ok),
        .rom_err   (rom_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] romf(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {a[18:16], 5'b0} ^ 8'h5A;
    endfunction

    assign rom_data = rnd_mode ? romf(rom_addr) : dir_data;
    assign rom_ok   = rnd_mode ? rnd_ok : dir_ok;

    typedef struct {
        logic        is_snd;
        logic [17:0] maddr;
        logic [14:0] saddr;
        int          dly;
        logic [7:0]  data;
        logic [18:0] exp_addr;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for rom_cs to reach a level. An expired bound is counted
    // as a failed comparison.
    task automatic wait_cs(input logic lvl, input string nm);
        int n = 0;
        while (rom_cs !== lvl && n < 20) begin
            tick();
            n++;
        end
        chk(nm, 32'(rom_cs), 32'(lvl));
    endtask

    // Serve one grant: check the address, hold rom_ok low for dly cycles,
    // then return data until rom_cs drops.
    task automatic fetch(input logic [18:0] exp_addr, input int dly,
                         input logic [7:0] data, input string nm);
        wait_cs(1'b1, {nm, "_cs"});
        chk({nm, "_addr"}, 32'(rom_addr), 32'(exp_addr));
        repeat (dly) tick();
        chk({nm, "_held"}, 32'(rom_cs), 32'd1);
        dir_ok   = 1'b1;
        dir_data = data;
        wait_cs(1'b0, {nm, "_done"});
        dir_ok   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        main_cs = 1'b0;
        snd_cs  = 1'b0;
        dir_ok  = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic        pcs;
    logic [18:0] paddr;

    // Per-cycle checks in random mode. Each rule follows from the ROM model
    // and the latch semantics:
    //   - an ok requester holds the ROM byte for its own address;
    //   - ok is never high without cs;
    //   - rom_addr does not move while rom_cs stays high.
    task automatic rcheck();
        if (main_ok) chk("rnd_main_data", 32'(main_data), 32'(romf(19'(main_addr))));
        if (!main_cs) chk("rnd_main_ok_nocs", 32'(main_ok), 32'd0);
        if (snd_ok) chk("rnd_snd_data", 32'(snd_data), 32'(romf(SND_BASE + 19'(snd_addr))));
        if (!snd_cs) chk("rnd_snd_ok_nocs", 32'(snd_ok), 32'd0);
        if (pcs && rom_cs) chk("rnd_addr_stable", 32'(rom_addr), 32'(paddr));
        pcs   = rom_cs;
        paddr = rom_addr;
    endtask

    initial begin
        rnd_mode  = 1'b0;
        rnd_ok    = 1'b0;
        dir_ok    = 1'b0;
        dir_data  = 8'h00;
        main_cs   = 1'b0;
        snd_cs    = 1'b0;
        main_addr = '0;
        snd_addr  = '0;
        pcs       = 1'b0;
        paddr     = '0;

        vecs[0] = '{1'b0, 18'h01234, 15'h0000, 3, 8'hA5, 19'h01234};
        vecs[1] = '{1'b1, 18'h00000, 15'h0010, 1, 8'h3C, 19'h40010};
        vecs[2] = '{1'b0, 18'h3FFFF, 15'h0000, 0, 8'h81, 19'h3FFFF};
        vecs[3] = '{1'b1, 18'h00000, 15'h7FFF, 5, 8'h7E, 19'h47FFF};

        do_reset();
        chk("rst_rom_cs",   32'(rom_cs),    32'd0);
        chk("rst_rom_addr", 32'(rom_addr),  32'd0);
        chk("rst_main_data", 32'(main_data), 32'd0);
        chk("rst_snd_data", 32'(snd_data),  32'd0);
        chk("rst_rom_err",  32'(rom_err),   32'd0);

        // ---- table: single-requester fetches ----
        for (int i = 0; i < 4; i++) begin
            main_cs   = !vecs[i].is_snd;
            snd_cs    = vecs[i].is_snd;
            main_addr = vecs[i].maddr;
            snd_addr  = vecs[i].saddr;
            fetch(vecs[i].exp_addr, vecs[i].dly, vecs[i].data, $sformatf("vec%0d", i));
            if (vecs[i].is_snd) begin
                chk($sformatf("vec%0d_snd_ok", i),   32'(snd_ok),   32'd1);
                chk($sformatf("vec%0d_snd_data", i), 32'(snd_data), 32'(vecs[i].data));
            end else begin
                chk($sformatf("vec%0d_main_ok", i),   32'(main_ok),   32'd1);
                chk($sformatf("vec%0d_main_data", i), 32'(main_data), 32'(vecs[i].data));
            end
            main_cs = 1'b0;
            snd_cs  = 1'b0;
            tick();
        end

        // ---- simultaneous requests after reset: main first ----
        do_reset();
        main_cs   = 1'b1; main_addr = 18'h00555;
        snd_cs    = 1'b1; snd_addr  = 15'h0123;
        fetch(19'h00555, 1, 8'h11, "rr_main");
        chk("rr_main_ok", 32'(main_ok), 32'd1);
        chk("rr_gap", 32'(rom_cs), 32'd0);
        tick();
        chk("rr_snd_cs", 32'(rom_cs), 32'd1);
        fetch(19'h40123, 1, 8'h22, "rr_snd");
        chk("rr_snd_ok", 32'(snd_ok), 32'd1);
        chk("rr_snd_data", 32'(snd_data), 32'h22);
        chk("rr_main_hold", 32'(main_ok), 32'd1);
        // make main the last served, then collide again: sound must go first
        main_addr = 18'h00777;
        fetch(19'h00777, 1, 8'h33, "rr_main2");
        tick();
        main_addr = 18'h00778;
        snd_addr  = 15'h0124;
        fetch(19'h40124, 1, 8'h44, "rr_snd_first");
        tick();
        fetch(19'h00778, 1, 8'h55, "rr_main_second");
        chk("rr2_ok", 32'({main_ok, snd_ok}), 32'd3);
        main_cs = 1'b0; snd_cs = 1'b0;
        tick();

        // ---- rom_ok stuck high before the grant: first cycle ignored ----
        dir_ok = 1'b1; dir_data = 8'h5C;
        tick();
        main_cs = 1'b1; main_addr = 18'h00999;
        tick();
        chk("stale_cs1", 32'(rom_cs), 32'd1);
        tick();
        chk("stale_cs2", 32'(rom_cs), 32'd1);
        chk("stale_ok2", 32'(main_ok), 32'd0);
        tick();
        chk("stale_cs3", 32'(rom_cs), 32'd0);
        chk("stale_data", 32'(main_data), 32'h5C);
        chk("stale_ok3", 32'(main_ok), 32'd1);
        dir_ok = 1'b0;
        main_cs = 1'b0;
        tick();

        // ---- address change mid-fetch ----
        main_cs = 1'b1; main_addr = 18'h00100;
        wait_cs(1'b1, "chg_cs");
        chk("chg_addr0", 32'(rom_addr), 32'h00100);
        main_addr = 18'h00101;
        dir_ok = 1'b1; dir_data = 8'hD0;
        wait_cs(1'b0, "chg_done0");
        dir_ok = 1'b0;
        chk("chg_ok_low", 32'(main_ok), 32'd0);
        tick();
        chk("chg_refetch", 32'(rom_cs), 32'd1);
        fetch(19'h00101, 1, 8'hD1, "chg_f1");
        chk("chg_ok1", 32'(main_ok), 32'd1);
        chk("chg_data1", 32'(main_data), 32'hD1);

        // ---- cs dropped mid-fetch, then re-raised on the same address ----
        main_addr = 18'h00200;
        wait_cs(1'b1, "drop_cs");
        main_cs = 1'b0;
        dir_ok = 1'b1; dir_data = 8'hE2;
        wait_cs(1'b0, "drop_done");
        dir_ok = 1'b0;
        chk("drop_ok_nocs", 32'(main_ok), 32'd0);
        tick();
        main_cs = 1'b1;
        #1;
        chk("drop_hit_ok", 32'(main_ok), 32'd1);
        chk("drop_hit_data", 32'(main_data), 32'hE2);
        tick();
        chk("drop_no_fetch1", 32'(rom_cs), 32'd0);
        tick();
        chk("drop_no_fetch2", 32'(rom_cs), 32'd0);

        // ---- reset in the middle of a fetch ----
        main_addr = 18'h00AAA;
        wait_cs(1'b1, "rstmid_cs");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_rom_cs", 32'(rom_cs), 32'd0);
        chk("rstmid_ok", 32'(main_ok), 32'd0);
        chk("rstmid_data", 32'(main_data), 32'd0);
        main_cs = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

`ifdef JTCASTLE_ROMARB_TIMEOUT_EN
        // ---- timeout: rom_ok never comes ----
        begin
            int n = 0;
            main_cs = 1'b1; main_addr = 18'h00042;
            wait_cs(1'b1, "tmo_cs");
            while (rom_cs && n < 100) begin
                n++;
                tick();
            end
            chk("tmo_cycles", 32'(n), 32'd16);
            chk("tmo_err", 32'(rom_err), 32'd1);
            chk("tmo_data", 32'(main_data), 32'hFF);
            chk("tmo_ok", 32'(main_ok), 32'd1);
            rst_n = 1'b0;
            #1;
            chk("tmo_err_clr", 32'(rom_err), 32'd0);
            main_cs = 1'b0;
            tick();
            rst_n = 1'b1;
            tick();
        end
`endif

        // ---- randomised phase against the ROM contents model ----
        rnd_mode = 1'b1;
        pcs = 1'b0;
        for (int ep = 0; ep < 300; ep++) begin
            int hold;
            main_cs   = ($urandom_range(0, 9) < 7);
            main_addr = 18'h00100 + 18'($urandom_range(0, 3));
            snd_cs    = ($urandom_range(0, 9) < 7);
            snd_addr  = 15'h0010 + 15'($urandom_range(0, 3));
            hold = $urandom_range(1, 12);
            for (int c = 0; c < hold; c++) begin
                rnd_ok = ($urandom_range(0, 3) != 0);
                #1;
                rcheck();
                tick();
            end
        end
        // both requests held: both must be answered within a bounded time
        begin
            int n = 0;
            main_cs = 1'b1; main_addr = 18'h00123;
            snd_cs  = 1'b1; snd_addr  = 15'h0456;
            while (!(main_ok && snd_ok) && n < 80) begin
                rnd_ok = ($urandom_range(0, 3) != 0);
                #1;
                rcheck();
                tick();
                n++;
            end
            chk("rnd_both_served", 32'({main_ok, snd_ok}), 32'd3);
            chk("rnd_final_main", 32'(main_data), 32'(romf(19'h00123)));
            chk("rnd_final_snd", 32'(snd_data), 32'(romf(19'h40456)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
